csr_irq_unit: RTL and testbench

Parametrised machine-mode CSR file and interrupt controller for the pipelined RV32 core. It generalises the single-line interrupt CSR unit to NUM_IRQ local interrupt lines, each with its own enable bit and level or edge mode. It supports direct and vectored trap modes and mret. It sits at the writeback boundary: it consumes the decoded CSR controls and the writeback PC, and drives the PC redirect into the fetch-stage interrupt mux.

---
 rtl/csr_irq_unit.sv | 167 ++++++++++++++++
 tb/tb_csr_irq_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_irq_unit.sv
// Machine-mode CSR file and multi-line interrupt controller.
// Takes traps / mret at writeback and redirects fetch for one cycle.
module csr_irq_unit #(
    parameter int                 XLEN        = 32,
    parameter int                 NUM_IRQ     = 8,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK   = '0,
    parameter logic [31:0]        MTVEC_RESET = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [XLEN-1:0]    pc_in,
    input  logic [XLEN-1:0]    csr_wdata,
    input  logic [11:0]        csr_addr,
    input  logic               csr_wr,
    input  logic               csr_rd,
    input  logic               csr_ret,
    input  logic               stall,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic [XLEN-1:0]    csr_rdata,
    output logic [XLEN-1:0]    trap_pc,
    output logic               trap_sel,
    output logic [NUM_IRQ-1:0] irq_ack
);

    typedef enum logic [1:0] {IDLE, TAKE, RET} state_t;

    state_t             state_q, state_d;
    logic [NUM_IRQ-1:0] sync1_q, sync2_q, sync_prev_q;
    logic [NUM_IRQ-1:0] pend_q, pend_d;
    logic [NUM_IRQ-1:0] mie_en_q, mie_en_d;
    logic               mie_q, mie_d;
    logic               mpie_q, mpie_d;
    logic [31:0]        mtvec_q, mtvec_d;
    logic [31:0]        mepc_q, mepc_d;
    logic [31:0]        mcause_q, mcause_d;
    logic [3:0]         idx_q, idx_d;

    logic [NUM_IRQ-1:0] hit;
    logic [3:0]         idx;
    logic               take, ret;
    logic               wr_mstatus, wr_mie, wr_mtvec;
    logic               wr_mepc, wr_mcause, wr_mip;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync_prev_q <= '0;
            pend_q      <= '0;
            mie_en_q    <= '0;
            mie_q       <= 1'b0;
            mpie_q      <= 1'b0;
            mtvec_q     <= MTVEC_RESET & 32'hFFFF_FFFD;
            mepc_q      <= '0;
            mcause_q    <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= irq_in;
            sync2_q     <= sync1_q;
            sync_prev_q <= sync2_q;
            pend_q      <= pend_d;
            mie_en_q    <= mie_en_d;
            mie_q       <= mie_d;
            mpie_q      <= mpie_d;
            mtvec_q     <= mtvec_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
            idx_q       <= idx_d;
        end
    end

    always_comb begin
        hit = pend_q & mie_en_q;
        idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (hit[i]) idx = 4'(i);
        end
        take = mie_q & (|hit) & ~stall & ~csr_ret & (state_q == IDLE);
        ret  = csr_ret & (state_q == IDLE);

        wr_mstatus = csr_wr & (csr_addr == 12'h300);
        wr_mie     = csr_wr & (csr_addr == 12'h304);
        wr_mtvec   = csr_wr & (csr_addr == 12'h305);
        wr_mepc    = csr_wr & (csr_addr == 12'h341);
        wr_mcause  = csr_wr & (csr_addr == 12'h342);
        wr_mip     = csr_wr & (csr_addr == 12'h344);

        state_d  = state_q;
        mie_en_d = mie_en_q;
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        idx_d    = idx_q;

        if (wr_mstatus) begin
            mie_d  = csr_wdata[3];
            mpie_d = csr_wdata[7];
        end
        if (wr_mie)    mie_en_d = csr_wdata[16 +: NUM_IRQ];
        if (wr_mtvec)  mtvec_d  = csr_wdata & 32'hFFFF_FFFD;
        if (wr_mepc)   mepc_d   = csr_wdata & 32'hFFFF_FFFC;
        if (wr_mcause) mcause_d = csr_wdata;

        // Edge lines latch a rising edge; a set on the same edge beats a clear.
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MASK[i]) begin
                pend_d[i] = (pend_q[i] & ~(wr_mip & ~csr_wdata[16 + i]))
                          | (sync2_q[i] & ~sync_prev_q[i]);
            end else begin
                pend_d[i] = sync2_q[i];
            end
        end

        unique case (state_q)
            IDLE:    state_d = ret ? RET : (take ? TAKE : IDLE);
            TAKE:    state_d = IDLE;
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (take) begin
            mepc_d   = pc_in & 32'hFFFF_FFFC;
            mcause_d = {1'b1, 26'd0, 1'b1, idx};
            mpie_d   = mie_q;
            mie_d    = 1'b0;
            idx_d    = idx;
        end else if (ret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
    end

    always_comb begin
        trap_sel = (state_q != IDLE);
        trap_pc  = '0;
        irq_ack  = '0;
        if (state_q == TAKE) begin
            trap_pc = {mtvec_q[31:2], 2'b00};
            if (mtvec_q[0]) trap_pc = trap_pc + {25'd0, 1'b1, idx_q, 2'b00};
            for (int i = 0; i < NUM_IRQ; i++) begin
                irq_ack[i] = (idx_q == 4'(i));
            end
        end else if (state_q == RET) begin
            trap_pc = mepc_q;
        end
    end

    always_comb begin
        csr_rdata = '0;
        if (csr_rd) begin
            case (csr_addr)
                12'h300: csr_rdata = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
                12'h304: csr_rdata[16 +: NUM_IRQ] = mie_en_q;
                12'h305: csr_rdata = mtvec_q;
                12'h341: csr_rdata = mepc_q;
                12'h342: csr_rdata = mcause_q;
                12'h344: csr_rdata[16 +: NUM_IRQ] = pend_q;
                default: csr_rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_irq_unit.sv
// Directed bench for csr_irq_unit: CSR table vectors plus trap,
// mret, priority, edge, stall and reset sequences.
module tb_csr_irq_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] csr_wdata;
    logic [11:0] csr_addr;
    logic        csr_wr;
    logic        csr_rd;
    logic        csr_ret;
    logic        stall;
    logic [7:0]  irq_in;
    logic [31:0] csr_rdata;
    logic [31:0] trap_pc;
    logic        trap_sel;
    logic [7:0]  irq_ack;

    int nvec = 0;
    int nfail = 0;

    csr_irq_unit #(
        .XLEN(32),
        .NUM_IRQ(8),
        .EDGE_MASK(8'h08),
        .MTVEC_RESET(32'h0000_0100)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc_in(pc_in),
        .csr_wdata(csr_wdata),
        .csr_addr(csr_addr),
        .csr_wr(csr_wr),
        .csr_rd(csr_rd),
        .csr_ret(csr_ret),
        .stall(stall),
        .irq_in(irq_in),
        .csr_rdata(csr_rdata),
        .trap_pc(trap_pc),
        .trap_sel(trap_sel),
        .irq_ack(irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
        csr_addr  = a;
        csr_wdata = d;
        csr_wr    = 1'b1;
        tick();
        csr_wr    = 1'b0;
    endtask

    task automatic csr_check(input string name, input logic [11:0] a,
                             input logic [31:0] exp);
        csr_addr = a;
        csr_rd   = 1'b1;
        #1;
        check(name, csr_rdata, exp);
        csr_rd   = 1'b0;
    endtask

    task automatic wait_trap(input int maxc, output int n);
        n = 0;
        while (!trap_sel && n < maxc) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        tbl[0] = '{12'h300, 32'hFFFF_FFFF, 32'h0000_0088};
        tbl[1] = '{12'h300, 32'h0000_0000, 32'h0000_0000};
        tbl[2] = '{12'h304, 32'hFFFF_FFFF, 32'h00FF_0000};
        tbl[3] = '{12'h304, 32'h0001_0000, 32'h0001_0000};
        tbl[4] = '{12'h305, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[5] = '{12'h305, 32'h0000_0200, 32'h0000_0200};
        tbl[6] = '{12'h341, 32'h0000_1237, 32'h0000_1234};
        tbl[7] = '{12'h342, 32'h8000_0003, 32'h8000_0003};
        tbl[8] = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[9] = '{12'h7C0, 32'h0000_DEAD, 32'h0000_0000};

        reset = 1'b0; pc_in = 32'h44; csr_wdata = '0; csr_addr = '0;
        csr_wr = 1'b0; csr_rd = 1'b0; csr_ret = 1'b0; stall = 1'b0;
        irq_in = '0;
        tick(); tick();
        check("reset_trap_sel", {31'd0, trap_sel}, 32'd0);
        check("reset_rdata", csr_rdata, 32'd0);
        reset = 1'b1;
        tick();
        csr_check("reset_mtvec", 12'h305, 32'h100);
        csr_check("reset_mstatus", 12'h300, 32'h0);
        csr_check("reset_mip", 12'h344, 32'h0);
        check("reset_trap_sel2", {31'd0, trap_sel}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            csr_write(tbl[i].addr, tbl[i].wdata);
            csr_check($sformatf("csr_vec%0d", i), tbl[i].addr, tbl[i].exp);
        end
        csr_addr = 12'h305;
        #1;
        check("rd_low_zero", csr_rdata, 32'h0);

        // level irq, direct mode
        csr_write(12'h300, 32'h8);
        irq_in = 8'h01;
        wait_trap(20, n);
        check("lvl_latency", n, 4);
        check("lvl_trap_sel", {31'd0, trap_sel}, 32'd1);
        check("lvl_trap_pc", trap_pc, 32'h200);
        check("lvl_ack", {24'd0, irq_ack}, 32'h01);
        irq_in = 8'h00;
        tick();
        check("lvl_one_cycle", {31'd0, trap_sel}, 32'd0);
        csr_check("lvl_mepc", 12'h341, 32'h44);
        csr_check("lvl_mcause", 12'h342, 32'h8000_0010);
        csr_check("lvl_mstatus", 12'h300, 32'h80);
        repeat (4) tick();

        // mret
        csr_ret = 1'b1;
        tick();
        csr_ret = 1'b0;
        check("ret_trap_sel", {31'd0, trap_sel}, 32'd1);
        check("ret_trap_pc", trap_pc, 32'h44);
        check("ret_ack", {24'd0, irq_ack}, 32'h0);
        csr_check("ret_mstatus", 12'h300, 32'h88);
        tick();
        check("ret_one_cycle", {31'd0, trap_sel}, 32'd0);

        // vectored priority
        csr_write(12'h305, 32'h301);
        csr_write(12'h304, 32'h0024_0000);
        irq_in = 8'h24;
        wait_trap(20, n);
        check("vec_trap_sel", {31'd0, trap_sel}, 32'd1);
        check("vec_trap_pc", trap_pc, 32'h348);
        check("vec_ack", {24'd0, irq_ack}, 32'h04);
        irq_in = 8'h00;
        tick();
        csr_check("vec_mcause", 12'h342, 32'h8000_0012);
        repeat (4) tick();

        // edge line with MIE=0
        csr_write(12'h304, 32'h0008_0000);
        csr_check("edge_mstatus", 12'h300, 32'h80);
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        repeat (5) tick();
        csr_check("edge_mip_held", 12'h344, 32'h0008_0000);
        csr_write(12'h344, 32'h0);
        csr_check("edge_mip_clr", 12'h344, 32'h0);
        csr_write(12'h300, 32'h8);
        wait_trap(6, n);
        check("edge_no_trap", {31'd0, trap_sel}, 32'd0);

        // mret beats a pending irq in the same cycle
        csr_write(12'h300, 32'h80);
        csr_write(12'h341, 32'h80);
        irq_in = 8'h08;
        tick();
        irq_in = 8'h00;
        repeat (4) tick();
        csr_check("mr_pend", 12'h344, 32'h0008_0000);
        csr_write(12'h300, 32'h88);
        csr_ret = 1'b1;
        tick();
        csr_ret = 1'b0;
        check("mr_ret_sel", {31'd0, trap_sel}, 32'd1);
        check("mr_ret_pc", trap_pc, 32'h80);
        check("mr_ret_ack", {24'd0, irq_ack}, 32'h0);
        tick();
        check("mr_gap", {31'd0, trap_sel}, 32'd0);
        tick();
        check("mr_take_sel", {31'd0, trap_sel}, 32'd1);
        check("mr_take_ack", {24'd0, irq_ack}, 32'h08);
        check("mr_take_pc", trap_pc, 32'h34C);
        tick();
        csr_check("mr_mcause", 12'h342, 32'h8000_0013);
        csr_check("mr_pend_kept", 12'h344, 32'h0008_0000);
        csr_write(12'h344, 32'h0);

        // stall defers the take
        csr_write(12'h304, 32'h0001_0000);
        csr_write(12'h305, 32'h200);
        csr_write(12'h300, 32'h8);
        stall = 1'b1;
        irq_in = 8'h01;
        repeat (3) tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall_c%0d", i), {31'd0, trap_sel}, 32'd0);
            tick();
        end
        check("stall_pend", {31'd0, trap_sel}, 32'd0);
        stall = 1'b0;
        tick();
        check("stall_release", {31'd0, trap_sel}, 32'd1);
        check("stall_pc", trap_pc, 32'h200);

        // async reset during TAKE
        #2;
        reset = 1'b0;
        #1;
        check("rst_mid_sel", {31'd0, trap_sel}, 32'd0);
        check("rst_mid_ack", {24'd0, irq_ack}, 32'h0);
        irq_in = 8'h00;
        tick();
        reset = 1'b1;
        tick();
        csr_check("rst_mid_mtvec", 12'h305, 32'h100);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
